fetch_pc_ctrl: RTL and testbench

- Owns the fetch PC and sequences instruction-fetch requests to the I-side memory port. At most one fetch is outstanding at a time.
- Arbitrates redirect sources by fixed priority: trap, then mem-stage branch resolve, then decode-stage predicted jump.
- Kills stale fetch responses when a redirect arrives while a fetch is in flight.
- Replaces the simple next-PC mux at the head of the pipeline; feeds the IF stage with (pc, inst) pairs.

---
 rtl/fetch_pc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
// Owns the fetch PC and issues instruction-fetch requests to the I-side memory
// port, with at most one fetch outstanding. Redirects are taken in fixed priority
// (trap, then mem-stage resolve, then decode-stage predicted jump). A redirect
// that arrives while a fetch is in flight kills the stale response. Delivered
// instructions go to the IF stage as registered (pc, inst) pairs.
//
// Ports:
//   clock, reset       core clock, asynchronous active-low reset
//   trap_en/trap_pc    trap redirect request and target (highest priority)
//   mem_pc_en/mem_pc   mem-stage mispredict redirect and target
//   dec_pc_en/dec_pc   decode-stage predicted-jump redirect and target
//   stall              IF stage cannot accept an instruction; no new requests
//   req_valid/req_pc   fetch request and address (req_ready: memory accepts)
//   resp_valid/inst    fetch response, always accepted
//   if_valid/pc/inst   registered one-cycle delivery to IF
//   busy               fetch outstanding or stale response pending
module fetch_pc_ctrl #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(64'h0000_0000_6000_0000)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mem_pc_en,
  input  logic [XLEN-1:0] mem_pc,
  input  logic            dec_pc_en,
  input  logic [XLEN-1:0] dec_pc,
  input  logic            stall,
  output logic            req_valid,
  output logic [XLEN-1:0] req_pc,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [31:0]     resp_inst,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   pc_nxt_s;
  logic [XLEN-1:0]   inflight_pc_r;
  logic [XLEN-1:0]   inflight_nxt_s;
  logic              redir_s;
  logic [XLEN-1:0]   sel_pc_s;
  logic              req_valid_s;
  logic              deliver_s;
  logic              busy_r;
  logic              if_valid_r;
  logic [XLEN-1:0]   if_pc_r;
  logic [31:0]       if_inst_r;

  // Fixed-priority redirect select: trap > mem-stage > decode-stage.
  always_comb begin
    redir_s = trap_en | mem_pc_en | dec_pc_en;
    if (trap_en) begin
      sel_pc_s = trap_pc;
    end else if (mem_pc_en) begin
      sel_pc_s = mem_pc;
    end else begin
      sel_pc_s = dec_pc;
    end
  end

  // Next-state, next-PC, request and delivery decode.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    inflight_nxt_s = inflight_pc_r;
    req_valid_s    = 1'b0;
    deliver_s      = 1'b0;
    case (state_r)
      // Redirects during the boot cycle are deliberately ignored.
      ST_BOOT: state_nxt_s = ST_RUN;
      ST_RUN: begin
        // A redirect withdraws any request in the same cycle.
        req_valid_s = !stall && !redir_s;
        if (redir_s) begin
          pc_nxt_s = sel_pc_s;
        end else if (req_valid_s && req_ready) begin
          inflight_nxt_s = pc_r;
          pc_nxt_s       = pc_r + XLEN'(3'd4);
          state_nxt_s    = ST_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (redir_s) begin
          pc_nxt_s = sel_pc_s;
          // A response coinciding with the redirect is stale: drop it now,
          // otherwise wait in FLUSH for it to arrive.
          if (resp_valid) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end else if (resp_valid) begin
          deliver_s   = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_FLUSH: begin
        if (redir_s) begin
          pc_nxt_s = sel_pc_s;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (resp_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: state_nxt_s = ST_BOOT;
    endcase
  end

  // State, fetch PC and in-flight PC registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_VECTOR;
      inflight_pc_r <= '0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      inflight_pc_r <= inflight_nxt_s;
      busy_r        <= (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_FLUSH);
    end
  end

  // Registered delivery to IF; pc/inst hold their last delivered value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_valid_r <= 1'b0;
      if_pc_r    <= '0;
      if_inst_r  <= 32'd0;
    end else begin
      if_valid_r <= deliver_s;
      if (deliver_s) begin
        if_pc_r   <= inflight_pc_r;
        if_inst_r <= resp_inst;
      end else begin
        if_pc_r   <= if_pc_r;
        if_inst_r <= if_inst_r;
      end
    end
  end

  assign req_valid = req_valid_s;
  assign req_pc    = pc_r;
  assign if_valid  = if_valid_r;
  assign if_pc     = if_pc_r;
  assign if_inst   = if_inst_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
module tb_fetch_pc_ctrl;

  localparam int XLEN = 64;

  logic            clock;
  logic            reset;
  logic            trap_en;
  logic [XLEN-1:0] trap_pc;
  logic            mem_pc_en;
  logic [XLEN-1:0] mem_pc;
  logic            dec_pc_en;
  logic [XLEN-1:0] dec_pc;
  logic            stall;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  logic            req_ready;
  logic            resp_valid;
  logic [31:0]     resp_inst;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_inst;
  logic            busy;

  int n_checks;
  int n_fail;

  fetch_pc_ctrl #(.XLEN(XLEN), .RESET_VECTOR(64'h0000_0000_6000_0000)) dut (
    .clock(clock), .reset(reset),
    .trap_en(trap_en), .trap_pc(trap_pc),
    .mem_pc_en(mem_pc_en), .mem_pc(mem_pc),
    .dec_pc_en(dec_pc_en), .dec_pc(dec_pc),
    .stall(stall),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic test_reset();
    @(negedge clock); #1;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%0h exp=0", req_valid); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid got=%0h exp=0", if_valid); end
    n_checks++; if (if_pc !== 64'h0) begin n_fail++; $display("FAIL rst_if_pc got=%0h exp=0", if_pc); end
    n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_if_inst got=%0h exp=0", if_inst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    n_checks++; if (req_pc !== 64'h6000_0000) begin n_fail++; $display("FAIL rst_req_pc got=%0h exp=60000000", req_pc); end
  endtask

  task automatic test_boot_first_fetch();
    @(negedge clock); reset = 1'b1; req_ready = 1'b1; #1;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_req_valid got=%0h exp=0", req_valid); end
    @(negedge clock); #1;
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid got=%0h exp=1", req_valid); end
    n_checks++; if (req_pc !== 64'h6000_0000) begin n_fail++; $display("FAIL first_req_pc got=%0h exp=60000000", req_pc); end
    @(negedge clock); resp_valid = 1'b1; resp_inst = 32'h0000_0013; #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_wait_busy got=%0h exp=1", busy); end
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL first_wait_req_valid got=%0h exp=0", req_valid); end
    @(negedge clock); resp_valid = 1'b0; req_ready = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL first_if_valid got=%0h exp=1", if_valid); end
    n_checks++; if (if_pc !== 64'h6000_0000) begin n_fail++; $display("FAIL first_if_pc got=%0h exp=60000000", if_pc); end
    n_checks++; if (if_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL first_if_inst got=%0h exp=13", if_inst); end
    n_checks++; if (req_pc !== 64'h6000_0004) begin n_fail++; $display("FAIL next_req_pc got=%0h exp=60000004", req_pc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_busy_clear got=%0h exp=0", busy); end
  endtask

  task automatic test_redirect_priority();
    @(negedge clock);
    req_ready = 1'b1;
    trap_en = 1'b1; trap_pc = 64'h8000_0000;
    mem_pc_en = 1'b1; mem_pc = 64'h6000_1000;
    dec_pc_en = 1'b1; dec_pc = 64'h6000_2000;
    #1;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL prio_redir_cycle_req got=%0h exp=0", req_valid); end
    @(negedge clock); trap_en = 1'b0; mem_pc_en = 1'b0; dec_pc_en = 1'b0; req_ready = 1'b0; #1;
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL prio_req_valid got=%0h exp=1", req_valid); end
    n_checks++; if (req_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL prio_req_pc got=%0h exp=80000000", req_pc); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL prio_if_valid got=%0h exp=0", if_valid); end
  endtask

  task automatic test_flush();
    @(negedge clock); req_ready = 1'b1;
    @(negedge clock); req_ready = 1'b0; mem_pc_en = 1'b1; mem_pc = 64'h6000_0100; #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_wait_busy got=%0h exp=1", busy); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); mem_pc_en = 1'b0; #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_%0d got=%0h exp=1", i, busy); end
      n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_%0d got=%0h exp=0", i, req_valid); end
    end
    @(negedge clock); resp_valid = 1'b1; resp_inst = 32'hDEAD_BEEF; #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_resp_busy got=%0h exp=1", busy); end
    @(negedge clock); resp_valid = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_if_valid got=%0h exp=0", if_valid); end
    n_checks++; if (if_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL flush_if_inst_hold got=%0h exp=13", if_inst); end
    n_checks++; if (if_pc !== 64'h6000_0000) begin n_fail++; $display("FAIL flush_if_pc_hold got=%0h exp=60000000", if_pc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_clear got=%0h exp=0", busy); end
    n_checks++; if (req_pc !== 64'h6000_0100) begin n_fail++; $display("FAIL flush_req_pc got=%0h exp=60000100", req_pc); end
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL flush_req_valid got=%0h exp=1", req_valid); end
  endtask

  task automatic test_redirect_with_resp();
    @(negedge clock); req_ready = 1'b1;
    @(negedge clock); req_ready = 1'b0; resp_valid = 1'b1; resp_inst = 32'h1111_1111;
    dec_pc_en = 1'b1; dec_pc = 64'h6000_0200; #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL same_busy got=%0h exp=1", busy); end
    @(negedge clock); resp_valid = 1'b0; dec_pc_en = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL same_if_valid got=%0h exp=0", if_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL same_busy_clear got=%0h exp=0", busy); end
    n_checks++; if (req_pc !== 64'h6000_0200) begin n_fail++; $display("FAIL same_req_pc got=%0h exp=60000200", req_pc); end
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL same_req_valid got=%0h exp=1", req_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock); req_ready = 1'b1;
    @(negedge clock); resp_valid = 1'b1; resp_inst = 32'hAAAA_0001; #1;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_wait_req got=%0h exp=0", req_valid); end
    @(negedge clock); resp_valid = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_if_valid0 got=%0h exp=1", if_valid); end
    n_checks++; if (if_pc !== 64'h6000_0200) begin n_fail++; $display("FAIL b2b_if_pc0 got=%0h exp=60000200", if_pc); end
    n_checks++; if (if_inst !== 32'hAAAA_0001) begin n_fail++; $display("FAIL b2b_if_inst0 got=%0h exp=aaaa0001", if_inst); end
    n_checks++; if (req_pc !== 64'h6000_0204) begin n_fail++; $display("FAIL b2b_req_pc1 got=%0h exp=60000204", req_pc); end
    @(negedge clock); resp_valid = 1'b1; resp_inst = 32'hBBBB_0002; #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_if_pulse got=%0h exp=0", if_valid); end
    @(negedge clock); resp_valid = 1'b0; req_ready = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_if_valid1 got=%0h exp=1", if_valid); end
    n_checks++; if (if_pc !== 64'h6000_0204) begin n_fail++; $display("FAIL b2b_if_pc1 got=%0h exp=60000204", if_pc); end
    n_checks++; if (if_inst !== 32'hBBBB_0002) begin n_fail++; $display("FAIL b2b_if_inst1 got=%0h exp=bbbb0002", if_inst); end
  endtask

  task automatic test_stall();
    // A stray resp_valid in RUN is a protocol error and must be ignored.
    @(negedge clock); stall = 1'b1; req_ready = 1'b1; resp_valid = 1'b1; resp_inst = 32'hCCCC_CCCC;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_%0d got=%0h exp=0", i, req_valid); end
      n_checks++; if (req_pc !== 64'h6000_0208) begin n_fail++; $display("FAIL stall_pc_%0d got=%0h exp=60000208", i, req_pc); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy_%0d got=%0h exp=0", i, busy); end
      @(negedge clock);
    end
    stall = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; #1;
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resume_req got=%0h exp=1", req_valid); end
    n_checks++; if (req_pc !== 64'h6000_0208) begin n_fail++; $display("FAIL stall_resume_pc got=%0h exp=60000208", req_pc); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_stray_resp got=%0h exp=0", if_valid); end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clock); dec_pc_en = 1'b1; dec_pc = 64'h6000_0008;
    @(negedge clock); dec_pc_en = 1'b0; req_ready = 1'b1; #1;
    n_checks++; if (req_pc !== 64'h6000_0008) begin n_fail++; $display("FAIL mid_req_pc got=%0h exp=60000008", req_pc); end
    @(negedge clock); req_ready = 1'b0; #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_wait_busy got=%0h exp=1", busy); end
    #1 reset = 1'b0; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%0h exp=0", busy); end
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req_valid got=%0h exp=0", req_valid); end
    n_checks++; if (if_pc !== 64'h0) begin n_fail++; $display("FAIL mid_rst_if_pc got=%0h exp=0", if_pc); end
    n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL mid_rst_if_inst got=%0h exp=0", if_inst); end
    n_checks++; if (req_pc !== 64'h6000_0000) begin n_fail++; $display("FAIL mid_rst_req_pc got=%0h exp=60000000", req_pc); end
    // Release with a trap pending: the boot cycle must ignore it.
    @(negedge clock); reset = 1'b1; req_ready = 1'b1; trap_en = 1'b1; trap_pc = 64'h1234_0000; #1;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_boot_req got=%0h exp=0", req_valid); end
    @(negedge clock); trap_en = 1'b0; req_ready = 1'b0; #1;
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_restart_req got=%0h exp=1", req_valid); end
    n_checks++; if (req_pc !== 64'h6000_0000) begin n_fail++; $display("FAIL mid_restart_pc got=%0h exp=60000000", req_pc); end
  endtask

  task automatic test_pc_wrap();
    @(negedge clock); trap_en = 1'b1; trap_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clock); trap_en = 1'b0; req_ready = 1'b1; #1;
    n_checks++; if (req_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_req_pc got=%0h exp=fffffffffffffffc", req_pc); end
    @(negedge clock); req_ready = 1'b0; resp_valid = 1'b1; resp_inst = 32'h0000_0013;
    @(negedge clock); resp_valid = 1'b0; #1;
    n_checks++; if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_if_pc got=%0h exp=fffffffffffffffc", if_pc); end
    n_checks++; if (req_pc !== 64'h0) begin n_fail++; $display("FAIL wrap_next_pc got=%0h exp=0", req_pc); end
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_req_valid got=%0h exp=1", req_valid); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; stall = 1'b0; req_ready = 1'b0;
    trap_en = 1'b0; trap_pc = 64'h0;
    mem_pc_en = 1'b0; mem_pc = 64'h0;
    dec_pc_en = 1'b0; dec_pc = 64'h0;
    resp_valid = 1'b0; resp_inst = 32'h0;
    test_reset();
    test_boot_first_fetch();
    test_redirect_priority();
    test_flush();
    test_redirect_with_resp();
    test_back_to_back();
    test_stall();
    test_reset_mid_fetch();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
